// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: steps a chain of layers through forward (0..L-1) then backprop (L-1..0) on one shared vector bus.
// Latency: 2*NUM_LAYERS*(strobe+wait+ack)+2 cycles; each layer holds valid until acked, so the sequencer simply stalls on it.
// Optional macro SEQ_WATCHDOG_EN adds a TIMEOUT-cycle watchdog per wait that raises a sticky err and aborts the step.
module mlp_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int VEC_W      = 63,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [VEC_W-1:0]            in_vec,
    input  logic [VEC_W-1:0]            target_vec,
    output logic                        busy,
    output logic                        done,
    output logic [VEC_W-1:0]            result_vec,
    output logic [VEC_W-1:0]            grad_vec,
    output logic                        err,
    output logic [VEC_W-1:0]            lay_vec,
    output logic [NUM_LAYERS-1:0]       lay_mult,
    output logic [NUM_LAYERS-1:0]       lay_backprop,
    output logic [NUM_LAYERS-1:0]       lay_ack,
    output logic [NUM_LAYERS-1:0]       lay_output_layer,
    input  logic [NUM_LAYERS-1:0]       lay_valid,
    input  logic [NUM_LAYERS*VEC_W-1:0] lay_vec_in
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FWD_ISSUE = 3'd1;
    localparam logic [2:0] S_FWD_WAIT  = 3'd2;
    localparam logic [2:0] S_FWD_ACK   = 3'd3;
    localparam logic [2:0] S_BWD_ISSUE = 3'd4;
    localparam logic [2:0] S_BWD_WAIT  = 3'd5;
    localparam logic [2:0] S_BWD_ACK   = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_busy;
    logic                  r_done;
    logic [VEC_W-1:0]      r_result;
    logic [VEC_W-1:0]      r_grad;
    logic [VEC_W-1:0]      r_lay_vec;
    logic [VEC_W-1:0]      r_target;
    logic [NUM_LAYERS-1:0] r_mult;
    logic [NUM_LAYERS-1:0] r_bp;
    logic [NUM_LAYERS-1:0] r_ack;

    logic                  w_valid;
    logic                  w_timeout;
    logic [VEC_W-1:0]      w_slice;
    logic [NUM_LAYERS-1:0] w_oh_cur;
    logic [NUM_LAYERS-1:0] w_oh_up;
    logic [NUM_LAYERS-1:0] w_oh_dn;

    assign busy             = r_busy;
    assign done             = r_done;
    assign result_vec       = r_result;
    assign grad_vec         = r_grad;
    assign lay_vec          = r_lay_vec;
    assign lay_mult         = r_mult;
    assign lay_backprop     = r_bp;
    assign lay_ack          = r_ack;
    assign lay_output_layer = NUM_LAYERS'(1) << (NUM_LAYERS - 1);

    // Only the addressed layer is observed; valid from any other layer is ignored.
    always_comb begin
        w_valid  = 1'b0;
        w_slice  = '0;
        w_oh_cur = '0;
        w_oh_up  = '0;
        w_oh_dn  = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_valid     = lay_valid[k];
                w_slice     = lay_vec_in[k*VEC_W +: VEC_W];
                w_oh_cur[k] = 1'b1;
            end
            if (IDX_W'(r_idx + IDX_W'(1)) == IDX_W'(k)) w_oh_up[k] = 1'b1;
            if (IDX_W'(r_idx - IDX_W'(1)) == IDX_W'(k)) w_oh_dn[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_grad    <= '0;
            r_lay_vec <= '0;
            r_target  <= '0;
            r_mult    <= '0;
            r_bp      <= '0;
            r_ack     <= '0;
        end else begin
            // Strobes are raised on the transition into their state so each lasts exactly one cycle.
            r_mult <= '0;
            r_bp   <= '0;
            r_ack  <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_target  <= target_vec;
                        r_lay_vec <= in_vec;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_mult    <= NUM_LAYERS'(1);
                        r_state   <= S_FWD_ISSUE;
                    end
                end
                S_FWD_ISSUE: r_state <= S_FWD_WAIT;
                S_FWD_WAIT: begin
                    if (w_valid) begin
                        r_lay_vec <= w_slice;
                        r_ack     <= w_oh_cur;
                        r_state   <= S_FWD_ACK;
                    end else if (w_timeout) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_FWD_ACK: begin
                    if (r_idx != LAST_IDX) begin
                        r_idx   <= IDX_W'(r_idx + IDX_W'(1));
                        r_mult  <= w_oh_up;
                        r_state <= S_FWD_ISSUE;
                    end else begin
                        r_result  <= r_lay_vec;
                        r_lay_vec <= r_target;
                        r_bp      <= w_oh_cur;
                        r_state   <= S_BWD_ISSUE;
                    end
                end
                S_BWD_ISSUE: r_state <= S_BWD_WAIT;
                S_BWD_WAIT: begin
                    if (w_valid) begin
                        r_lay_vec <= w_slice;
                        r_ack     <= w_oh_cur;
                        r_state   <= S_BWD_ACK;
                    end else if (w_timeout) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_BWD_ACK: begin
                    if (r_idx != '0) begin
                        r_idx   <= IDX_W'(r_idx - IDX_W'(1));
                        r_bp    <= w_oh_dn;
                        r_state <= S_BWD_ISSUE;
                    end else begin
                        r_grad  <= r_lay_vec;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;
    logic            w_in_wait;

    assign w_in_wait = (r_state == S_FWD_WAIT) || (r_state == S_BWD_WAIT);
    assign w_timeout = w_in_wait && !w_valid && (r_wd_cnt == WD_W'(TIMEOUT - 1));
    assign err       = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (!w_in_wait) begin
                r_wd_cnt <= '0;
            end else if (!w_valid && !w_timeout) begin
                r_wd_cnt <= WD_W'(r_wd_cnt + WD_W'(1));
            end
            if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    localparam int wd_timeout_unused = TIMEOUT;

    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: a 3-layer and a 1-layer instance driven by behavioural layer models.
module tb_mlp_layer_sequencer;
    localparam int VW = 63;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic          start3, start1;
    logic [VW-1:0] in3, tgt3, in1, tgt1;
    logic          busy3, done3, err3, busy1, done1, err1;
    logic [VW-1:0] res3, grad3, lv3, res1, grad1, lv1;
    logic [2:0]    mult3, bp3, ack3, ol3, vld3;
    logic [0:0]    mult1, bp1, ack1, ol1, vld1;
    logic [3*VW-1:0] vin3;
    logic [VW-1:0]   vin1;

    logic [3:0]    m_all, b_all, a_all, v_all;
    logic [VW-1:0] out_v [4];

    assign m_all = {mult1, mult3};
    assign b_all = {bp1, bp3};
    assign a_all = {ack1, ack3};
    assign vld3  = v_all[2:0];
    assign vld1  = v_all[3:3];
    assign vin3  = {out_v[2], out_v[1], out_v[0]};
    assign vin1  = out_v[3];

    mlp_layer_sequencer #(.NUM_LAYERS(3), .VEC_W(VW), .TIMEOUT(255)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .in_vec(in3), .target_vec(tgt3),
        .busy(busy3), .done(done3), .result_vec(res3), .grad_vec(grad3), .err(err3),
        .lay_vec(lv3), .lay_mult(mult3), .lay_backprop(bp3), .lay_ack(ack3),
        .lay_output_layer(ol3), .lay_valid(vld3), .lay_vec_in(vin3));

    mlp_layer_sequencer #(.NUM_LAYERS(1), .VEC_W(VW), .TIMEOUT(255)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .in_vec(in1), .target_vec(tgt1),
        .busy(busy1), .done(done1), .result_vec(res1), .grad_vec(grad1), .err(err1),
        .lay_vec(lv1), .lay_mult(mult1), .lay_backprop(bp1), .lay_ack(ack1),
        .lay_output_layer(ol1), .lay_valid(vld1), .lay_vec_in(vin1));

    int total = 0;
    int bad   = 0;
    int dly [4];
    int st [4];
    int cnt [4];
    int since [4];
    bit isbp [4];
    logic [VW-1:0] lat [4];
    logic [VW-1:0] bp_top [2];
    int log3[$];
    int log1[$];
    int done3_cnt, done1_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] rep(input logic [6:0] a);
        return {9{a}};
    endfunction

    // Layer behaviour: forward adds 1 per lane, backprop of layer k xors (k+1) then adds 3.
    function automatic logic [VW-1:0] lane_fwd(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        for (int l = 0; l < 9; l++) r[l*7 +: 7] = v[l*7 +: 7] + 7'd1;
        return r;
    endfunction

    function automatic logic [VW-1:0] lane_bwd(input logic [VW-1:0] v, input int k);
        logic [VW-1:0] r;
        for (int l = 0; l < 9; l++) r[l*7 +: 7] = (v[l*7 +: 7] ^ 7'(k + 1)) + 7'd3;
        return r;
    endfunction

    function automatic logic [VW-1:0] ref_res(input int nl, input logic [VW-1:0] v);
        logic [VW-1:0] r;
        int x;
        for (int l = 0; l < 9; l++) begin
            x = int'(v[l*7 +: 7]);
            x = (x + nl) % 128;
            r[l*7 +: 7] = 7'(x);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] ref_grad(input int nl, input logic [VW-1:0] t);
        logic [VW-1:0] r;
        int x;
        for (int l = 0; l < 9; l++) begin
            x = int'(t[l*7 +: 7]);
            for (int k = nl - 1; k >= 0; k--) x = ((x ^ (k + 1)) + 3) % 128;
            r[l*7 +: 7] = 7'(x);
        end
        return r;
    endfunction

    // Layer models: slots 0..2 belong to dut3, slot 3 to dut1.
    initial begin : layer_models
        logic [VW-1:0] vv;
        bit stb;
        int ly;
        v_all = '0;
        for (int s = 0; s < 4; s++) begin
            out_v[s] = '0;
            st[s] = 0;
        end
        done3_cnt = 0;
        done1_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                for (int s = 0; s < 4; s++) st[s] = 0;
                v_all = '0;
            end else begin
                chk("dut3 strobes one-hot", 64'($countones({mult3, bp3, ack3}) > 1), 64'(0));
                chk("dut1 strobes one-hot", 64'($countones({mult1, bp1, ack1}) > 1), 64'(0));
                if (done3) done3_cnt++;
                if (done1) done1_cnt++;
                for (int s = 0; s < 4; s++) begin
                    stb = m_all[s] | b_all[s];
                    ly  = (s < 3) ? s : 0;
                    vv  = (s < 3) ? lv3 : lv1;
                    if (st[s] == 0) begin
                        chk($sformatf("ack idle slot %0d", s), 64'(a_all[s]), 64'(0));
                        if (stb) begin
                            lat[s]  = vv;
                            isbp[s] = b_all[s];
                            cnt[s]  = dly[s];
                            st[s]   = 1;
                            if (s < 3) log3.push_back((b_all[s] ? 16 : 0) + ly + 1);
                            else       log1.push_back((b_all[s] ? 16 : 0) + ly + 1);
                            if (b_all[s] && s == 2) bp_top[0] = vv;
                            if (b_all[s] && s == 3) bp_top[1] = vv;
                        end
                    end else if (st[s] == 1) begin
                        chk($sformatf("ack busy slot %0d", s), 64'(a_all[s]), 64'(0));
                        chk($sformatf("strobe width slot %0d", s), 64'(stb), 64'(0));
                        cnt[s]--;
                        if (cnt[s] <= 0) begin
                            out_v[s] = isbp[s] ? lane_bwd(lat[s], ly) : lane_fwd(lat[s]);
                            v_all[s] = 1'b1;
                            st[s] = 2;
                            since[s] = 0;
                        end
                    end else begin
                        since[s]++;
                        chk($sformatf("ack timing slot %0d", s), 64'(a_all[s]), 64'(since[s] == 1));
                        chk($sformatf("strobe while valid slot %0d", s), 64'(stb), 64'(0));
                        if (a_all[s]) begin
                            v_all[s] = 1'b0;
                            st[s] = 0;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [63:0] exp_seq(input int nl);
        logic [63:0] q = '0;
        for (int k = 0; k < nl; k++) q = (q << 8) | 64'(k + 1);
        for (int k = nl - 1; k >= 0; k--) q = (q << 8) | 64'(16 + k + 1);
        return q;
    endfunction

    function automatic logic [63:0] act_seq(input int sel);
        logic [63:0] q = '0;
        if (sel == 0) foreach (log3[j]) q = (q << 8) | 64'(log3[j]);
        else          foreach (log1[j]) q = (q << 8) | 64'(log1[j]);
        return q;
    endfunction

    // Wait for done with a cycle bound; called on a negedge.
    task automatic wait_done(input string nm, input int sel, output int cyc);
        cyc = 1;
        while (((sel == 0) ? done3 : done1) !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) chk({nm, " done timeout"}, 64'(0), 64'(1));
    endtask

    // d>0: uniform layer delay and latency check; d==0 keeps the delays already set.
    task automatic do_step(input string nm, input int sel, input logic [VW-1:0] vi,
                           input logic [VW-1:0] vt, input int d, input logic [VW-1:0] er,
                           input logic [VW-1:0] eg);
        int nl;
        int cyc;
        nl = (sel == 0) ? 3 : 1;
        if (d > 0) for (int s = 0; s < 4; s++) dly[s] = d;
        bp_top[sel] = '0;
        if (sel == 0) begin
            log3.delete(); done3_cnt = 0; in3 = vi; tgt3 = vt; start3 = 1'b1;
        end else begin
            log1.delete(); done1_cnt = 0; in1 = vi; tgt1 = vt; start1 = 1'b1;
        end
        @(negedge clk);
        start3 = 1'b0;
        start1 = 1'b0;
        wait_done(nm, sel, cyc);
        chk({nm, " result_vec"}, 64'((sel == 0) ? res3 : res1), 64'(er));
        chk({nm, " grad_vec"}, 64'((sel == 0) ? grad3 : grad1), 64'(eg));
        chk({nm, " err"}, 64'((sel == 0) ? err3 : err1), 64'(0));
        chk({nm, " busy in done"}, 64'((sel == 0) ? busy3 : busy1), 64'(1));
        chk({nm, " target on top backprop"}, 64'(bp_top[sel]), 64'(vt));
        chk({nm, " strobe order"}, act_seq(sel), exp_seq(nl));
        if (d > 0) chk({nm, " latency"}, 64'(cyc), 64'(2 * nl * (d + 2) + 1));
        @(negedge clk);
        chk({nm, " busy after"}, 64'((sel == 0) ? busy3 : busy1), 64'(0));
        chk({nm, " done pulses"}, 64'((sel == 0) ? done3_cnt : done1_cnt), 64'(1));
    endtask

    typedef struct {
        int         sel;
        logic [6:0] in_l;
        logic [6:0] tg_l;
        int         d;
        logic [6:0] res_l;
        logic [6:0] grd_l;
    } vec_t;

    initial begin : main
        vec_t tbl [6];
        logic [VW-1:0] va, vb, vt;
        int cyc;
        tbl[0] = '{0, 7'd5,   7'd3,   2,  7'd8, 7'd8};
        tbl[1] = '{0, 7'd0,   7'd0,   1,  7'd3, 7'd9};
        tbl[2] = '{0, 7'd126, 7'd127, 20, 7'd1, 7'd4};
        tbl[3] = '{0, 7'd127, 7'd100, 3,  7'd2, 7'd109};
        tbl[4] = '{1, 7'd5,   7'd3,   2,  7'd6, 7'd5};
        tbl[5] = '{1, 7'd127, 7'd0,   1,  7'd0, 7'd4};

        reset_n = 1'b0;
        start3 = 1'b0; start1 = 1'b0;
        in3 = '0; tgt3 = '0; in1 = '0; tgt1 = '0;
        for (int s = 0; s < 4; s++) dly[s] = 2;
        bp_top[0] = '0; bp_top[1] = '0;
        repeat (3) @(negedge clk);

        chk("reset busy3", 64'(busy3), 64'(0));
        chk("reset done3", 64'(done3), 64'(0));
        chk("reset err3", 64'(err3), 64'(0));
        chk("reset strobes3", 64'({mult3, bp3, ack3}), 64'(0));
        chk("reset lay_vec3", 64'(lv3), 64'(0));
        chk("reset result3", 64'(res3), 64'(0));
        chk("reset grad3", 64'(grad3), 64'(0));
        chk("output_layer3", 64'(ol3), 64'(3'b100));
        chk("output_layer1", 64'(ol1), 64'(1));
        chk("reset strobes1", 64'({mult1, bp1, ack1, busy1, done1}), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            do_step($sformatf("vec%0d", i), tbl[i].sel, rep(tbl[i].in_l), rep(tbl[i].tg_l),
                    tbl[i].d, rep(tbl[i].res_l), rep(tbl[i].grd_l));

        for (int i = 0; i < 12; i++) begin
            int sel;
            sel = (i % 3 == 2) ? 1 : 0;
            for (int s = 0; s < 4; s++) dly[s] = $urandom_range(1, 6);
            va = VW'({$urandom(), $urandom()});
            vt = VW'({$urandom(), $urandom()});
            do_step($sformatf("rnd%0d", i), sel, va, vt, 0,
                    ref_res(sel == 0 ? 3 : 1, va), ref_grad(sel == 0 ? 3 : 1, vt));
        end

        // A second start during a busy step must be ignored.
        for (int s = 0; s < 4; s++) dly[s] = 20;
        va = VW'({$urandom(), $urandom()});
        vb = VW'({$urandom(), $urandom()});
        vt = VW'({$urandom(), $urandom()});
        log3.delete(); done3_cnt = 0;
        in3 = va; tgt3 = vt; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (10) @(negedge clk);
        in3 = vb; tgt3 = vb; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_done("busy-start", 0, cyc);
        chk("busy-start result_vec", 64'(res3), 64'(ref_res(3, va)));
        chk("busy-start grad_vec", 64'(grad3), 64'(ref_grad(3, vt)));
        repeat (10) @(negedge clk);
        chk("busy-start idle after", 64'(busy3), 64'(0));
        chk("busy-start done pulses", 64'(done3_cnt), 64'(1));
        chk("busy-start strobe order", act_seq(0), exp_seq(3));

        // Reset in the middle of the first forward wait.
        log3.delete();
        in3 = rep(7'd9); tgt3 = rep(7'd9); start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid-wait busy", 64'(busy3), 64'(1));
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid-reset busy3", 64'(busy3), 64'(0));
        chk("mid-reset strobes3", 64'({mult3, bp3, ack3}), 64'(0));
        chk("mid-reset lay_vec3", 64'(lv3), 64'(0));
        chk("mid-reset result3", 64'(res3), 64'(0));
        chk("mid-reset grad3", 64'(grad3), 64'(0));
        chk("mid-reset done3", 64'(done3), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        do_step("after-reset", 0, rep(7'd5), rep(7'd3), 2, rep(7'd8), rep(7'd8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : guard
        #500000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/mlp_layer_sequencer.md
Name: mlp_layer_sequencer

Overview:
- Sequences a chain of NUM_LAYERS matrix-multiply layer modules through one training step: forward pass layer 0 → L-1, then backprop L-1 → 0.
- Drives one shared 63-bit (7x9 packed) vector bus and per-layer mult/backprop/ack strobes; collects each layer's packed output on valid.
- Sits between the host/sample loader and the layer array.

Parameters:
- NUM_LAYERS, 3, number of layer instances (≥1); the last is the output layer.
- VEC_W, 63, packed vector width (7 bits × 9 lanes).
- TIMEOUT, 255, cycles to wait for a layer valid before error (watchdog feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  host pulse: begin a step; sampled only in IDLE.
- in_vec  in  VEC_W  sample input, captured on start.
- target_vec  in  VEC_W  expected output y, captured on start.
- busy  out  1  high from the cycle after start until DONE exits.
- done  out  1  one-cycle pulse at end of step.
- result_vec  out  VEC_W  forward output of layer NUM_LAYERS-1, held until next start.
- grad_vec  out  VEC_W  delta returned by layer 0, held until next start.
- err  out  1  watchdog error flag (0 when feature absent).
- lay_vec  out  VEC_W  shared bus to every layer's packed input.
- lay_mult  out  NUM_LAYERS  per-layer forward strobe.
- lay_backprop  out  NUM_LAYERS  per-layer backprop strobe.
- lay_ack  out  NUM_LAYERS  per-layer ack.
- lay_output_layer  out  NUM_LAYERS  constant; only bit NUM_LAYERS-1 set.
- lay_valid  in  NUM_LAYERS  per-layer valid.
- lay_vec_in  in  NUM_LAYERS*VEC_W  concatenated layer outputs, layer k at bits [k*VEC_W +: VEC_W].

Behaviour:
- Reset (async, any state): state=IDLE, idx=0; busy, done, err, all lay_mult/lay_backprop/lay_ack = 0; lay_vec, result_vec, grad_vec = 0. All outputs registered except lay_output_layer.
- States: IDLE, FWD_ISSUE, FWD_WAIT, FWD_ACK, BWD_ISSUE, BWD_WAIT, BWD_ACK, DONE.
- IDLE: on start, latch target_vec, set lay_vec=in_vec, idx=0, busy=1, go to FWD_ISSUE. start in any other state is ignored.
- FWD_ISSUE: lay_mult[idx]=1 for exactly one cycle with lay_vec stable; go to FWD_WAIT.
- FWD_WAIT: on lay_valid[idx]=1, capture that layer's output slice into lay_vec, assert lay_ack[idx] for one cycle next cycle; go to FWD_ACK. Valid on any other bit is ignored.
- FWD_ACK: lay_ack deasserts. If idx<NUM_LAYERS-1: idx+1, go to FWD_ISSUE. Else result_vec=lay_vec, lay_vec=target, go to BWD_ISSUE. idx is unchanged.
- BWD_ISSUE: lay_backprop[idx]=1 for one cycle with lay_vec holding target (idx=NUM_LAYERS-1) or the downstream delta. lay_vec held unchanged for ≥2 cycles around the strobe. Go to BWD_WAIT.
- BWD_WAIT/BWD_ACK: same capture/ack rule as forward. After ack, if idx>0 then idx-1 and go to BWD_ISSUE; else grad_vec=lay_vec, go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Ack is a single-cycle pulse issued the cycle after valid is first sampled high. The layer holds valid until it sees ack, so no valid is lost.
- At most one strobe bit set at any time. Strobes are never asserted to idx≠current.
- NUM_LAYERS=1: the forward then immediately backprops the same layer with target.
- Latency per step with ideal layers (valid two cycles after mult/backprop strobe): 2·NUM_LAYERS·(strobe+wait+ack) + 2 cycles.
- idx counter is $clog2(NUM_LAYERS) bits (min 1); no wrap beyond 0 or NUM_LAYERS-1.

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- Defined: a counter resets on entry to FWD_WAIT/BWD_WAIT. If TIMEOUT cycles elapse without lay_valid[idx]: err=1 (sticky until reset_n), strobes cleared, done pulse, go to IDLE. result_vec and grad_vec are not updated on error.
- Undefined: no counter, err tied 0, waits indefinitely.

Test Plan:
- Reset mid-FWD_WAIT (reset_n low 1 cycle) → next cycle all strobes 0, busy=0, state IDLE; a following start runs a normal step.
- NUM_LAYERS=3 with layer models returning in+1 per lane, in_vec lanes all 5 → lay_mult pulses on bits 0,1,2 in order; result_vec lanes =8; lay_backprop order 2,1,0; done single pulse; busy low after.
- Layer valid delayed 20 cycles → ack issued exactly one cycle after valid rises, width 1; no strobe to other layers meanwhile.
- start asserted while busy → ignored; result_vec unchanged until the active step's done.
- NUM_LAYERS=1, target lanes 3 → lay_mult[0] then lay_backprop[0] with lay_vec=target on the strobe cycle; grad_vec = model's returned delta.
- SEQ_WATCHDOG_EN, TIMEOUT=10, layer 1 never valid → err=1 at cycle 10 of wait, done pulses, grad_vec stays 0.
